// File: rtl/bsg_mem_sp_wbuf_pkg.sv
// Shared types and helpers for the single-port SRAM + write-buffer 1R1W memory.
// Holds the SRAM port-owner encoding and the bitwise mask-merge used by forwarding.
package bsg_mem_sp_wbuf_pkg;

    // Widest data word the merge helper handles; callers zero-extend and truncate.
    localparam int merge_width_lp = 1024;

    typedef enum logic [1:0] {
        e_port_idle,
        e_port_read,
        e_port_drain,
        e_port_bypass
    } port_owner_e;

    function automatic logic [merge_width_lp-1:0] merge(
        input logic [merge_width_lp-1:0] old_data,
        input logic [merge_width_lp-1:0] new_data,
        input logic [merge_width_lp-1:0] mask
    );
        return (old_data & ~mask) | (new_data & mask);
    endfunction

endpackage

// File: rtl/bsg_mem_1r1w_sp_wbuf_if.sv
// Read/write port bundle of the 1R1W memory; the master drives requests, the slave is the memory.
interface bsg_mem_1r1w_sp_wbuf_if #(
    parameter int width_p      = 32,
    parameter int addr_width_p = 3
);
    logic                    w_v_i;
    logic [addr_width_p-1:0] w_addr_i;
    logic [width_p-1:0]      w_data_i;
    logic [width_p-1:0]      w_mask_i;
    logic                    w_ready_o;
    logic                    r_v_i;
    logic [addr_width_p-1:0] r_addr_i;
    logic                    r_v_o;
    logic [width_p-1:0]      r_data_o;
    logic                    wbuf_empty_o;

    modport master (
        output w_v_i, w_addr_i, w_data_i, w_mask_i, r_v_i, r_addr_i,
        input  w_ready_o, r_v_o, r_data_o, wbuf_empty_o
    );

    modport slave (
        input  w_v_i, w_addr_i, w_data_i, w_mask_i, r_v_i, r_addr_i,
        output w_ready_o, r_v_o, r_data_o, wbuf_empty_o
    );
endinterface

// File: rtl/bsg_mem_sp_wbuf_cam.sv
// Circular write buffer with an age-ordered address match: every pending entry that hits the
// probe address is overlaid oldest-to-youngest, yielding the bits a read must take from the buffer.
module bsg_mem_sp_wbuf_cam
    import bsg_mem_sp_wbuf_pkg::*;
#(
    parameter int width_p      = 32,
    parameter int addr_width_p = 3,
    parameter int els_p        = 2,
    localparam int ptr_width_lp   = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int count_width_lp = $clog2(els_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    push_i,
    input  logic [addr_width_p-1:0] push_addr_i,
    input  logic [width_p-1:0]      push_data_i,
    input  logic [width_p-1:0]      push_mask_i,
    input  logic                    pop_i,
    output logic [addr_width_p-1:0] head_addr_o,
    output logic [width_p-1:0]      head_data_o,
    output logic [width_p-1:0]      head_mask_o,
    output logic                    full_o,
    output logic                    empty_o,
    input  logic [addr_width_p-1:0] match_addr_i,
    output logic [width_p-1:0]      fwd_data_o,
    output logic [width_p-1:0]      fwd_mask_o
);
    logic [ptr_width_lp-1:0]   head_reg, head_next;
    logic [ptr_width_lp-1:0]   tail_reg, tail_next;
    logic [count_width_lp-1:0] count_reg, count_next;

    logic [addr_width_p-1:0] addr_mem [els_p];
    logic [width_p-1:0]      data_mem [els_p];
    logic [width_p-1:0]      mask_mem [els_p];

    function automatic logic [ptr_width_lp-1:0] next_ptr(input logic [ptr_width_lp-1:0] p);
        return (32'(p) == els_p - 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        head_next  = pop_i  ? next_ptr(head_reg) : head_reg;
        tail_next  = push_i ? next_ptr(tail_reg) : tail_reg;
        count_next = count_reg + count_width_lp'(push_i) - count_width_lp'(pop_i);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            addr_mem[tail_reg] <= push_addr_i;
            data_mem[tail_reg] <= push_data_i;
            mask_mem[tail_reg] <= push_mask_i;
        end
    end

    assign head_addr_o = addr_mem[head_reg];
    assign head_data_o = data_mem[head_reg];
    assign head_mask_o = mask_mem[head_reg];
    assign full_o      = (count_reg == count_width_lp'(els_p));
    assign empty_o     = (count_reg == '0);

    // Age 0 is the head (oldest); an age slot is live only while it is below the count.
    logic [ptr_width_lp-1:0] age_slot [els_p];
    logic [els_p-1:0]        age_hit;

    for (genvar gi = 0; gi < els_p; gi++) begin : g_age
        assign age_slot[gi] = ptr_width_lp'((32'(head_reg) + 32'(gi)) % els_p);
        assign age_hit[gi]  = (32'(count_reg) > 32'(gi))
                              && (addr_mem[age_slot[gi]] == match_addr_i);
    end

    logic [width_p-1:0] fwd_data_acc;
    logic [width_p-1:0] fwd_mask_acc;

    always_comb begin
        fwd_data_acc = '0;
        fwd_mask_acc = '0;
        for (int k = 0; k < els_p; k++) begin
            if (age_hit[k]) begin
                fwd_data_acc = width_p'(merge(merge_width_lp'(fwd_data_acc),
                                              merge_width_lp'(data_mem[age_slot[k]]),
                                              merge_width_lp'(mask_mem[age_slot[k]])));
                fwd_mask_acc = fwd_mask_acc | mask_mem[age_slot[k]];
            end
        end
    end

    assign fwd_data_o = fwd_data_acc;
    assign fwd_mask_o = fwd_mask_acc;

    assert property (@(posedge clk_i) disable iff (!reset_n_i) !(pop_i && empty_o));
    assert property (@(posedge clk_i) disable iff (!reset_n_i) !(push_i && full_o && !pop_i));
endmodule

// File: rtl/bsg_mem_sp_wbuf_sram.sv
// Behavioural single-port SRAM macro: shared address, registered read, active-low bit write mask.
module bsg_mem_sp_wbuf_sram #(
    parameter int width_p      = 32,
    parameter int els_p        = 8,
    parameter int addr_width_p = 3
) (
    input  logic                    clk_i,
    input  logic                    v_i,
    input  logic                    w_i,
    input  logic [addr_width_p-1:0] addr_i,
    input  logic [width_p-1:0]      data_i,
    input  logic [width_p-1:0]      w_mask_n_i,
    output logic [width_p-1:0]      data_o
);
    logic [width_p-1:0] mem [els_p];

    // Contents are deliberately not reset, matching a real macro.
    always_ff @(posedge clk_i) begin
        if (v_i && w_i) begin
            mem[addr_i] <= (mem[addr_i] & w_mask_n_i) | (data_i & ~w_mask_n_i);
        end
        if (v_i && !w_i) begin
            data_o <= mem[addr_i];
        end
    end
endmodule

// File: rtl/bsg_mem_1r1w_sp_wbuf.sv
// 1R1W memory on a single-port SRAM: reads own the port, writes queue in a small buffer and
// drain on read-idle cycles; reads see buffered data through a registered forwarding overlay.
module bsg_mem_1r1w_sp_wbuf
    import bsg_mem_sp_wbuf_pkg::*;
#(
    parameter int width_p                = 32,
    parameter int els_p                  = 8,
    parameter int wbuf_els_p             = 2,
    parameter int read_write_same_addr_p = 0,
    localparam int addr_width_lp = $clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    bsg_mem_1r1w_sp_wbuf_if.slave    bus
);
    logic                     full;
    logic                     empty;
    logic [addr_width_lp-1:0] head_addr;
    logic [width_p-1:0]       head_data;
    logic [width_p-1:0]       head_mask;
    logic [width_p-1:0]       cam_fwd_data;
    logic [width_p-1:0]       cam_fwd_mask;

    logic        w_ready;
    logic        w_accept;
    logic        push;
    logic        pop;
    port_owner_e owner;

    // A free port (no read) always lets a write in: it either drains a slot or bypasses.
    assign w_ready  = reset_n_i && (!full || !bus.r_v_i);
    assign w_accept = bus.w_v_i && w_ready;

    always_comb begin
        owner = e_port_idle;
        if (bus.r_v_i) begin
            owner = e_port_read;
        end else if (!empty) begin
            owner = e_port_drain;
        end else if (w_accept) begin
            owner = e_port_bypass;
        end
    end

    assign push = w_accept && (owner != e_port_bypass);
    assign pop  = (owner == e_port_drain);

    bsg_mem_sp_wbuf_cam #(
        .width_p      (width_p),
        .addr_width_p (addr_width_lp),
        .els_p        (wbuf_els_p)
    ) cam (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .push_i       (push),
        .push_addr_i  (bus.w_addr_i),
        .push_data_i  (bus.w_data_i),
        .push_mask_i  (bus.w_mask_i),
        .pop_i        (pop),
        .head_addr_o  (head_addr),
        .head_data_o  (head_data),
        .head_mask_o  (head_mask),
        .full_o       (full),
        .empty_o      (empty),
        .match_addr_i (bus.r_addr_i),
        .fwd_data_o   (cam_fwd_data),
        .fwd_mask_o   (cam_fwd_mask)
    );

    logic                     sram_v;
    logic                     sram_w;
    logic [addr_width_lp-1:0] sram_addr;
    logic [width_p-1:0]       sram_data;
    logic [width_p-1:0]       sram_mask_n;
    logic [width_p-1:0]       sram_q;

    always_comb begin
        sram_v      = 1'b0;
        sram_w      = 1'b0;
        sram_addr   = bus.r_addr_i;
        sram_data   = bus.w_data_i;
        sram_mask_n = ~bus.w_mask_i;
        unique case (owner)
            e_port_read: begin
                sram_v = 1'b1;
            end
            e_port_drain: begin
                sram_v      = 1'b1;
                sram_w      = 1'b1;
                sram_addr   = head_addr;
                sram_data   = head_data;
                sram_mask_n = ~head_mask;
            end
            e_port_bypass: begin
                sram_v    = 1'b1;
                sram_w    = 1'b1;
                sram_addr = bus.w_addr_i;
            end
            default: ;
        endcase
    end

    bsg_mem_sp_wbuf_sram #(
        .width_p      (width_p),
        .els_p        (els_p),
        .addr_width_p (addr_width_lp)
    ) sram (
        .clk_i      (clk_i),
        .v_i        (sram_v),
        .w_i        (sram_w),
        .addr_i     (sram_addr),
        .data_i     (sram_data),
        .w_mask_n_i (sram_mask_n),
        .data_o     (sram_q)
    );

    logic               r_v_reg;
    logic [width_p-1:0] fwd_data_reg, fwd_data_next;
    logic [width_p-1:0] fwd_mask_reg, fwd_mask_next;

    // The overlay is frozen at the request cycle so later drains cannot change what this read sees.
    always_comb begin
        fwd_data_next = cam_fwd_data;
        fwd_mask_next = cam_fwd_mask;
        if ((read_write_same_addr_p != 0) && bus.r_v_i && w_accept
            && (bus.w_addr_i == bus.r_addr_i)) begin
            fwd_data_next = width_p'(merge(merge_width_lp'(cam_fwd_data),
                                           merge_width_lp'(bus.w_data_i),
                                           merge_width_lp'(bus.w_mask_i)));
            fwd_mask_next = cam_fwd_mask | bus.w_mask_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_v_reg      <= 1'b0;
            fwd_data_reg <= '0;
            fwd_mask_reg <= '0;
        end else begin
            r_v_reg      <= bus.r_v_i;
            fwd_data_reg <= fwd_data_next;
            fwd_mask_reg <= fwd_mask_next;
        end
    end

    assign bus.w_ready_o    = w_ready;
    assign bus.wbuf_empty_o = empty;
    assign bus.r_v_o        = r_v_reg;
    assign bus.r_data_o     = r_v_reg
                              ? width_p'(merge(merge_width_lp'(sram_q),
                                               merge_width_lp'(fwd_data_reg),
                                               merge_width_lp'(fwd_mask_reg)))
                              : '0;

    assert property (@(posedge clk_i) disable iff (!reset_n_i)
                     bus.r_v_i |-> (32'(bus.r_addr_i) < els_p));
    assert property (@(posedge clk_i) disable iff (!reset_n_i)
                     bus.w_v_i |-> (32'(bus.w_addr_i) < els_p));
endmodule

// File: tb/tb_bsg_mem_1r1w_sp_wbuf.sv
// Directed bench for the single-port write-buffered 1R1W memory; two instances differ only in
// same-cycle read/write forwarding and receive identical stimulus.
module tb_bsg_mem_1r1w_sp_wbuf;
    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bsg_mem_1r1w_sp_wbuf_if #(.width_p(32), .addr_width_p(3)) bus0();
    bsg_mem_1r1w_sp_wbuf_if #(.width_p(32), .addr_width_p(3)) bus1();

    assign bus1.w_v_i    = bus0.w_v_i;
    assign bus1.w_addr_i = bus0.w_addr_i;
    assign bus1.w_data_i = bus0.w_data_i;
    assign bus1.w_mask_i = bus0.w_mask_i;
    assign bus1.r_v_i    = bus0.r_v_i;
    assign bus1.r_addr_i = bus0.r_addr_i;

    bsg_mem_1r1w_sp_wbuf #(.width_p(32), .els_p(8), .wbuf_els_p(2), .read_write_same_addr_p(0))
        dut0 (.clk_i(clk), .reset_n_i(reset_n), .bus(bus0));
    bsg_mem_1r1w_sp_wbuf #(.width_p(32), .els_p(8), .wbuf_els_p(2), .read_write_same_addr_p(1))
        dut1 (.clk_i(clk), .reset_n_i(reset_n), .bus(bus1));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wv, input logic [2:0] wa, input logic [31:0] wd,
                         input logic [31:0] wm, input logic rv, input logic [2:0] ra);
        bus0.w_v_i    = wv;
        bus0.w_addr_i = wa;
        bus0.w_data_i = wd;
        bus0.w_mask_i = wm;
        bus0.r_v_i    = rv;
        bus0.r_addr_i = ra;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 3'd0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b1, 3'd1, 32'h1234, 32'hFFFF_FFFF, 1'b0, 3'd0);
        checks++; if (bus0.w_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", bus0.w_ready_o); end
        step(); step();
        checks++; if (bus0.r_v_o !== 1'b0) begin errors++; $display("FAIL rst_rv: got %b expected 0", bus0.r_v_o); end
        checks++; if (bus0.r_data_o !== 32'h0) begin errors++; $display("FAIL rst_data: got %h expected 00000000", bus0.r_data_o); end
        checks++; if (bus0.wbuf_empty_o !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b expected 1", bus0.wbuf_empty_o); end
        idle();
        reset_n = 1'b1;
        #1;
        checks++; if (bus0.w_ready_o !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", bus0.w_ready_o); end
        step();
        $display("test_reset done");
    endtask

    task automatic test_bypass();
        drive(1'b1, 3'd3, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, 3'd0);
        checks++; if (bus0.w_ready_o !== 1'b1) begin errors++; $display("FAIL bypass_ready: got %b expected 1", bus0.w_ready_o); end
        step();
        checks++; if (bus0.wbuf_empty_o !== 1'b1) begin errors++; $display("FAIL bypass_empty: got %b expected 1", bus0.wbuf_empty_o); end
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 3'd3);
        checks++; if (bus0.r_v_o !== 1'b0) begin errors++; $display("FAIL bypass_latency: got %b expected 0", bus0.r_v_o); end
        step();
        checks++; if (bus0.r_v_o !== 1'b1) begin errors++; $display("FAIL bypass_rv: got %b expected 1", bus0.r_v_o); end
        checks++; if (bus0.r_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_data: got %h expected deadbeef", bus0.r_data_o); end
        idle();
        step();
        checks++; if (bus0.r_data_o !== 32'h0) begin errors++; $display("FAIL bypass_idle_data: got %h expected 00000000", bus0.r_data_o); end
        $display("test_bypass: write addr3 deadbeef, read back %h", 32'hDEAD_BEEF);
    endtask

    task automatic test_buffer_forward();
        drive(1'b1, 3'd5, 32'h1111_2222, 32'hFFFF_FFFF, 1'b1, 3'd3);
        step();
        checks++; if (bus0.wbuf_empty_o !== 1'b0) begin errors++; $display("FAIL buf_enqueued: got %b expected 0", bus0.wbuf_empty_o); end
        checks++; if (bus0.r_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL buf_read3: got %h expected deadbeef", bus0.r_data_o); end
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 3'd5);
        step();
        checks++; if (bus0.r_data_o !== 32'h1111_2222) begin errors++; $display("FAIL buf_forward: got %h expected 11112222", bus0.r_data_o); end
        idle();
        step();
        checks++; if (bus0.wbuf_empty_o !== 1'b1) begin errors++; $display("FAIL buf_drained: got %b expected 1", bus0.wbuf_empty_o); end
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 3'd5);
        step();
        checks++; if (bus0.r_data_o !== 32'h1111_2222) begin errors++; $display("FAIL buf_sram: got %h expected 11112222", bus0.r_data_o); end
        idle();
        step();
        $display("test_buffer_forward: addr5 forwarded and drained");
    endtask

    task automatic test_partial_mask();
        drive(1'b1, 3'd2, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 1'b0, 3'd0);
        step();
        drive(1'b1, 3'd2, 32'h5555_5555, 32'h0000_FFFF, 1'b1, 3'd2);
        step();
        checks++; if (bus0.r_data_o !== 32'hAAAA_AAAA) begin errors++; $display("FAIL mask_same_cycle_p0: got %h expected aaaaaaaa", bus0.r_data_o); end
        checks++; if (bus1.r_data_o !== 32'hAAAA_5555) begin errors++; $display("FAIL mask_same_cycle_p1: got %h expected aaaa5555", bus1.r_data_o); end
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 3'd2);
        step();
        checks++; if (bus0.r_data_o !== 32'hAAAA_5555) begin errors++; $display("FAIL mask_forward: got %h expected aaaa5555", bus0.r_data_o); end
        idle();
        step();
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 3'd2);
        step();
        checks++; if (bus0.r_data_o !== 32'hAAAA_5555) begin errors++; $display("FAIL mask_sram: got %h expected aaaa5555", bus0.r_data_o); end
        idle();
        step();
        $display("test_partial_mask: addr2 merged to aaaa5555");
    endtask

    task automatic test_same_addr();
        drive(1'b1, 3'd7, 32'h0, 32'hFFFF_FFFF, 1'b0, 3'd0);
        step();
        drive(1'b1, 3'd7, 32'h7, 32'hFFFF_FFFF, 1'b1, 3'd7);
        step();
        checks++; if (bus0.r_data_o !== 32'h0) begin errors++; $display("FAIL same_addr_p0: got %h expected 00000000", bus0.r_data_o); end
        checks++; if (bus1.r_data_o !== 32'h7) begin errors++; $display("FAIL same_addr_p1: got %h expected 00000007", bus1.r_data_o); end
        idle();
        step();
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 3'd7);
        step();
        checks++; if (bus0.r_data_o !== 32'h7) begin errors++; $display("FAIL same_addr_sram: got %h expected 00000007", bus0.r_data_o); end
        idle();
        step();
        $display("test_same_addr: addr7 p0 old data, p1 new data");
    endtask

    task automatic test_full();
        drive(1'b1, 3'd0, 32'h100, 32'hFFFF_FFFF, 1'b1, 3'd3);
        checks++; if (bus0.w_ready_o !== 1'b1) begin errors++; $display("FAIL full_ready0: got %b expected 1", bus0.w_ready_o); end
        step();
        drive(1'b1, 3'd1, 32'h101, 32'hFFFF_FFFF, 1'b1, 3'd3);
        checks++; if (bus0.w_ready_o !== 1'b1) begin errors++; $display("FAIL full_ready1: got %b expected 1", bus0.w_ready_o); end
        step();
        drive(1'b1, 3'd4, 32'h104, 32'hFFFF_FFFF, 1'b1, 3'd3);
        checks++; if (bus0.w_ready_o !== 1'b0) begin errors++; $display("FAIL full_backpressure: got %b expected 0", bus0.w_ready_o); end
        step();
        drive(1'b1, 3'd4, 32'h104, 32'hFFFF_FFFF, 1'b0, 3'd0);
        checks++; if (bus0.w_ready_o !== 1'b1) begin errors++; $display("FAIL full_drain_push: got %b expected 1", bus0.w_ready_o); end
        step();
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 3'd1);
        checks++; if (bus0.w_ready_o !== 1'b0) begin errors++; $display("FAIL full_count2: got %b expected 0", bus0.w_ready_o); end
        step();
        checks++; if (bus0.r_data_o !== 32'h101) begin errors++; $display("FAIL full_forward: got %h expected 00000101", bus0.r_data_o); end
        idle();
        step();
        checks++; if (bus0.wbuf_empty_o !== 1'b0) begin errors++; $display("FAIL full_drain1: got %b expected 0", bus0.wbuf_empty_o); end
        step();
        checks++; if (bus0.wbuf_empty_o !== 1'b1) begin errors++; $display("FAIL full_drain2: got %b expected 1", bus0.wbuf_empty_o); end
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 3'd4);
        step();
        checks++; if (bus0.r_data_o !== 32'h104) begin errors++; $display("FAIL full_sram4: got %h expected 00000104", bus0.r_data_o); end
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 3'd0);
        step();
        checks++; if (bus0.r_data_o !== 32'h100) begin errors++; $display("FAIL full_sram0: got %h expected 00000100", bus0.r_data_o); end
        idle();
        step();
        $display("test_full: backpressure then drain+push, addrs 0/1/4 landed");
    endtask

    task automatic test_mask_zero();
        drive(1'b1, 3'd3, 32'h0, 32'h0, 1'b1, 3'd3);
        step();
        checks++; if (bus0.wbuf_empty_o !== 1'b0) begin errors++; $display("FAIL mask0_slot: got %b expected 0", bus0.wbuf_empty_o); end
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 3'd3);
        step();
        checks++; if (bus0.r_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mask0_no_effect: got %h expected deadbeef", bus0.r_data_o); end
        idle();
        step();
        checks++; if (bus0.wbuf_empty_o !== 1'b1) begin errors++; $display("FAIL mask0_drained: got %b expected 1", bus0.wbuf_empty_o); end
        $display("test_mask_zero: empty-mask write occupied a slot, addr3 unchanged");
    endtask

    task automatic test_reset_mid_drain();
        drive(1'b1, 3'd6, 32'h66, 32'hFFFF_FFFF, 1'b0, 3'd0);
        step();
        drive(1'b1, 3'd6, 32'hBAD0, 32'hFFFF_FFFF, 1'b1, 3'd3);
        step();
        drive(1'b1, 3'd6, 32'hBAD1, 32'hFFFF_FFFF, 1'b1, 3'd3);
        step();
        checks++; if (bus0.r_v_o !== 1'b1) begin errors++; $display("FAIL rstmid_pre_rv: got %b expected 1", bus0.r_v_o); end
        reset_n = 1'b0;
        idle();
        checks++; if (bus0.r_v_o !== 1'b0) begin errors++; $display("FAIL rstmid_rv: got %b expected 0", bus0.r_v_o); end
        checks++; if (bus0.r_data_o !== 32'h0) begin errors++; $display("FAIL rstmid_data: got %h expected 00000000", bus0.r_data_o); end
        checks++; if (bus0.wbuf_empty_o !== 1'b1) begin errors++; $display("FAIL rstmid_empty: got %b expected 1", bus0.wbuf_empty_o); end
        checks++; if (bus0.w_ready_o !== 1'b0) begin errors++; $display("FAIL rstmid_ready: got %b expected 0", bus0.w_ready_o); end
        step(); step();
        reset_n = 1'b1;
        drive(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 3'd6);
        step();
        checks++; if (bus0.r_data_o !== 32'h66) begin errors++; $display("FAIL rstmid_discard: got %h expected 00000066", bus0.r_data_o); end
        idle();
        step();
        $display("test_reset_mid_drain: buffered addr6 writes discarded");
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_bypass();
        test_buffer_forward();
        test_partial_mask();
        test_same_addr();
        test_full();
        test_mask_zero();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
